// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared sizing constants for the hazard scoreboard
package hazard_scoreboard_pkg;

    localparam int SB_NREGS     = 32;
    localparam int SB_REGNOBITS = 5;
    localparam int SB_CNTBITS   = 2;
    localparam int SB_CNT_MAX   = (1 << SB_CNTBITS) - 1;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode/WB/AGEX signal bundle for the hazard scoreboard
interface hazard_scoreboard_if #(
    parameter int NREGS     = hazard_scoreboard_pkg::SB_NREGS,
    parameter int REGNOBITS = hazard_scoreboard_pkg::SB_REGNOBITS,
    parameter int CNTBITS   = hazard_scoreboard_pkg::SB_CNTBITS
);
    logic                         issue_valid;
    logic                         use_rs1;
    logic                         use_rs2;
    logic [REGNOBITS-1:0]         rs1;
    logic [REGNOBITS-1:0]         rs2;
    logic                         wr_reg;
    logic [REGNOBITS-1:0]         rd;
    logic                         br_mispred;
    logic                         retire_valid;
    logic [REGNOBITS-1:0]         retire_rd;
    logic                         kill_valid;
    logic [REGNOBITS-1:0]         kill_rd;
    logic                         stall;
    logic                         issue_fire;
    logic [NREGS-1:0]             busy_mask;
    logic [REGNOBITS+CNTBITS-1:0] inflight_total;
    logic                         sb_error;

    modport master (
        output issue_valid, use_rs1, use_rs2, rs1, rs2, wr_reg, rd, br_mispred,
               retire_valid, retire_rd, kill_valid, kill_rd,
        input  stall, issue_fire, busy_mask, inflight_total, sb_error
    );

    modport slave (
        input  issue_valid, use_rs1, use_rs2, rs1, rs2, wr_reg, rd, br_mispred,
               retire_valid, retire_rd, kill_valid, kill_rd,
        output stall, issue_fire, busy_mask, inflight_total, sb_error
    );
endinterface

// File: rtl/hazard_scoreboard_sb_counter.sv
// rtl/hazard_scoreboard_sb_counter.sv - per-register saturating in-flight writer counter
module sb_counter
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNTBITS = SB_CNTBITS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    input  logic               dec_ret,
    input  logic               dec_kill,
    output logic [CNTBITS-1:0] cnt,
    output logic [CNTBITS-1:0] cnt_next,
    output logic               nonzero,
    output logic               err
);
    localparam int SW = CNTBITS + 2;
    localparam logic signed [SW-1:0] MAXV = SW'((1 << CNTBITS) - 1);

    logic signed [SW-1:0] sum;

    // Two extra bits hold the -2..max+1 range before clamping.
    always_comb begin
        sum      = $signed({2'b00, cnt}) + $signed(SW'(inc))
                 - $signed(SW'(dec_ret)) - $signed(SW'(dec_kill));
        err      = 1'b0;
        cnt_next = sum[CNTBITS-1:0];
        if (sum < 0) begin
            cnt_next = '0;
            err      = 1'b1;
        end else if (sum > MAXV) begin
            cnt_next = '1;
            err      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt_next;
    end

    assign nonzero = |cnt;
endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register writer scoreboard and DE issue/stall decision
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREGS     = SB_NREGS,
    parameter int REGNOBITS = SB_REGNOBITS,
    parameter int CNTBITS   = SB_CNTBITS,
    parameter int WB_BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_scoreboard_if.slave sb
);
    localparam int TOTW = REGNOBITS + CNTBITS;
    localparam logic [CNTBITS-1:0] CMAX = '1;
    localparam logic [CNTBITS-1:0] CONE = CNTBITS'(1);

    logic [NREGS-1:0][CNTBITS-1:0] cnt;
    logic [NREGS-1:0][CNTBITS-1:0] cnt_nx;
    logic [NREGS-1:0]              nonzero;
    logic [NREGS-1:0]              err;
    logic [TOTW-1:0]               total_nx;
    logic [TOTW-1:0]               total_q;
    logic                          error_q;
    logic                          raw1, raw2, strct, stall, fire;

    // A retire landing on the last pending writer forwards through WB this cycle.
    always_comb begin
        raw1  = sb.use_rs1 && (sb.rs1 != '0) && (cnt[sb.rs1] != '0)
             && !((WB_BYPASS != 0) && sb.retire_valid && (sb.retire_rd == sb.rs1)
                  && (cnt[sb.rs1] == CONE));
        raw2  = sb.use_rs2 && (sb.rs2 != '0) && (cnt[sb.rs2] != '0)
             && !((WB_BYPASS != 0) && sb.retire_valid && (sb.retire_rd == sb.rs2)
                  && (cnt[sb.rs2] == CONE));
        strct = sb.wr_reg && (sb.rd != '0) && (cnt[sb.rd] == CMAX);
    end

    assign stall = !rst_n || sb.br_mispred || (sb.issue_valid && (raw1 || raw2 || strct));
    assign fire  = sb.issue_valid && !stall;

    assign cnt[0]     = '0;
    assign cnt_nx[0]  = '0;
    assign nonzero[0] = 1'b0;
    assign err[0]     = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
        sb_counter #(.CNTBITS(CNTBITS)) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .inc      (fire && sb.wr_reg && (sb.rd == REGNOBITS'(r))),
            .dec_ret  (sb.retire_valid && (sb.retire_rd == REGNOBITS'(r))),
            .dec_kill (sb.kill_valid && (sb.kill_rd == REGNOBITS'(r))),
            .cnt      (cnt[r]),
            .cnt_next (cnt_nx[r]),
            .nonzero  (nonzero[r]),
            .err      (err[r])
        );
    end

    // Summing next-state values keeps the total aligned with the counters.
    always_comb begin
        total_nx = '0;
        for (int r = 0; r < NREGS; r++) total_nx = total_nx + TOTW'(cnt_nx[r]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q <= '0;
            error_q <= 1'b0;
        end else begin
            total_q <= total_nx;
            error_q <= error_q || (|err);
        end
    end

    assign sb.stall          = stall;
    assign sb.issue_fire     = fire;
    assign sb.busy_mask      = nonzero;
    assign sb.inflight_total = total_q;
    assign sb.sb_error       = error_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if sb_if ();

    hazard_scoreboard #(.WB_BYPASS(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        sb_if.issue_valid  = 1'b0;
        sb_if.use_rs1      = 1'b0;
        sb_if.use_rs2      = 1'b0;
        sb_if.rs1          = '0;
        sb_if.rs2          = '0;
        sb_if.wr_reg       = 1'b0;
        sb_if.rd           = '0;
        sb_if.br_mispred   = 1'b0;
        sb_if.retire_valid = 1'b0;
        sb_if.retire_rd    = '0;
        sb_if.kill_valid   = 1'b0;
        sb_if.kill_rd      = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue_wr(input logic [4:0] r);
        sb_if.issue_valid = 1'b1;
        sb_if.wr_reg      = 1'b1;
        sb_if.rd          = r;
    endtask

    task automatic retire(input logic [4:0] r);
        sb_if.retire_valid = 1'b1;
        sb_if.retire_rd    = r;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        issue_wr(5'd5);
        #2;
        check_eq("rst_stall", sb_if.stall, 1);
        check_eq("rst_fire", sb_if.issue_fire, 0);
        check_eq("rst_busy", sb_if.busy_mask, 0);
        check_eq("rst_total", sb_if.inflight_total, 0);
        check_eq("rst_err", sb_if.sb_error, 0);
        @(posedge clk); #1;
        check_eq("rst_busy_edge", sb_if.busy_mask, 0);
        idle();
        rst_n = 1'b1;

        // basic RAW with WB bypass on reg 5
        issue_wr(5'd5); #1;
        check_eq("r5_stall", sb_if.stall, 0);
        check_eq("r5_fire", sb_if.issue_fire, 1);
        tick();
        check_eq("r5_busy", sb_if.busy_mask, 32'h0000_0020);
        check_eq("r5_total", sb_if.inflight_total, 1);
        sb_if.issue_valid = 1'b1; sb_if.use_rs1 = 1'b1; sb_if.rs1 = 5'd5; #1;
        check_eq("r5_raw_stall", sb_if.stall, 1);
        check_eq("r5_raw_fire", sb_if.issue_fire, 0);
        retire(5'd5); #1;
        check_eq("r5_bypass_stall", sb_if.stall, 0);
        check_eq("r5_bypass_fire", sb_if.issue_fire, 1);
        tick();
        check_eq("r5_clear_busy", sb_if.busy_mask, 0);
        check_eq("r5_clear_total", sb_if.inflight_total, 0);

        // WAW on reg 7 up to saturation
        for (int i = 0; i < 3; i++) begin
            issue_wr(5'd7); #1;
            check_eq("r7_fire", sb_if.issue_fire, 1);
            tick();
        end
        check_eq("r7_total3", sb_if.inflight_total, 3);
        check_eq("r7_busy3", sb_if.busy_mask, 32'h0000_0080);
        issue_wr(5'd7); retire(5'd7); #1;
        check_eq("r7_struct_stall", sb_if.stall, 1);
        check_eq("r7_struct_fire", sb_if.issue_fire, 0);
        tick();
        check_eq("r7_total2", sb_if.inflight_total, 2);
        sb_if.issue_valid = 1'b1; sb_if.use_rs1 = 1'b1; sb_if.rs1 = 5'd7; retire(5'd7); #1;
        check_eq("r7_nobypass_cnt2", sb_if.stall, 1);
        tick();
        check_eq("r7_total1", sb_if.inflight_total, 1);
        check_eq("r7_busy1", sb_if.busy_mask, 32'h0000_0080);
        sb_if.issue_valid = 1'b1; sb_if.use_rs1 = 1'b1; sb_if.rs1 = 5'd7; retire(5'd7); #1;
        check_eq("r7_bypass_cnt1", sb_if.stall, 0);
        tick();
        check_eq("r7_total0", sb_if.inflight_total, 0);
        check_eq("r7_busy0", sb_if.busy_mask, 0);

        // register 0 is never tracked
        sb_if.issue_valid = 1'b1; sb_if.use_rs1 = 1'b1; sb_if.use_rs2 = 1'b1;
        sb_if.wr_reg = 1'b1; retire(5'd0); sb_if.kill_valid = 1'b1; #1;
        check_eq("r0_stall", sb_if.stall, 0);
        tick();
        check_eq("r0_busy", sb_if.busy_mask, 0);
        check_eq("r0_total", sb_if.inflight_total, 0);
        check_eq("r0_err", sb_if.sb_error, 0);
        sb_if.issue_valid = 1'b1; sb_if.use_rs1 = 1'b1; #1;
        check_eq("r0_raw_stall", sb_if.stall, 0);
        tick();

        // reg 9: retire+kill together, then underflow
        issue_wr(5'd9); tick();
        issue_wr(5'd9); tick();
        check_eq("r9_total2", sb_if.inflight_total, 2);
        retire(5'd9); sb_if.kill_valid = 1'b1; sb_if.kill_rd = 5'd9; tick();
        check_eq("r9_total0", sb_if.inflight_total, 0);
        check_eq("r9_busy0", sb_if.busy_mask, 0);
        check_eq("r9_err0", sb_if.sb_error, 0);
        retire(5'd9); tick();
        check_eq("r9_under_total", sb_if.inflight_total, 0);
        check_eq("r9_under_err", sb_if.sb_error, 1);

        // mispredict forces stall
        issue_wr(5'd4); sb_if.br_mispred = 1'b1; #1;
        check_eq("mp_stall", sb_if.stall, 1);
        check_eq("mp_fire", sb_if.issue_fire, 0);
        tick();
        check_eq("mp_total", sb_if.inflight_total, 0);
        check_eq("mp_busy", sb_if.busy_mask, 0);
        sb_if.br_mispred = 1'b1; #1;
        check_eq("mp_idle_stall", sb_if.stall, 1);
        tick();

        // reg 3: rs2 RAW, then simultaneous issue and retire
        issue_wr(5'd3); tick();
        check_eq("r3_total1", sb_if.inflight_total, 1);
        sb_if.issue_valid = 1'b1; sb_if.use_rs2 = 1'b1; sb_if.rs2 = 5'd3; #1;
        check_eq("r3_rs2_stall", sb_if.stall, 1);
        idle();
        issue_wr(5'd3); retire(5'd3); #1;
        check_eq("r3_swap_fire", sb_if.issue_fire, 1);
        tick();
        check_eq("r3_swap_total", sb_if.inflight_total, 1);
        check_eq("r3_swap_busy", sb_if.busy_mask, 32'h0000_0008);
        check_eq("err_sticky", sb_if.sb_error, 1);

        // mid-cycle asynchronous reset with four writers in flight
        issue_wr(5'd10); tick();
        issue_wr(5'd11); tick();
        issue_wr(5'd12); tick();
        check_eq("pre_rst_total", sb_if.inflight_total, 4);
        #2;
        rst_n = 1'b0;
        issue_wr(5'd13);
        #1;
        check_eq("arst_total", sb_if.inflight_total, 0);
        check_eq("arst_busy", sb_if.busy_mask, 0);
        check_eq("arst_err", sb_if.sb_error, 0);
        check_eq("arst_stall", sb_if.stall, 1);
        check_eq("arst_fire", sb_if.issue_fire, 0);
        tick();
        rst_n = 1'b1;
        issue_wr(5'd6); #1;
        check_eq("post_rst_fire", sb_if.issue_fire, 1);
        tick();
        check_eq("post_rst_total", sb_if.inflight_total, 1);
        check_eq("post_rst_busy", sb_if.busy_mask, 32'h0000_0040);
        retire(5'd3); tick();
        check_eq("stale_retire_err", sb_if.sb_error, 1);
        check_eq("stale_retire_total", sb_if.inflight_total, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
